// File: rtl/ras_ckpt.sv
// Circular return-address stack with a FIFO of speculative checkpoints.
// Calls push, returns pop, and in-order branch resolution frees or repairs the stack.
module ras_ckpt #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int NCKPT = 4,
  parameter int CADDR = $clog2(NCKPT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             branch,
  input  logic             close_valid,
  input  logic             close_invalid,
  output logic [WIDTH-1:0] dout,
  output logic [ADDR:0]    count,
  output logic             empty,
  output logic             ckpt_full,
  output logic             overflow,
  output logic             underflow,
  output logic             ckpt_drop
);

  // A single-entry queue still needs a 1-bit pointer to index with.
  localparam int CA = (CADDR > 0) ? CADDR : 1;
  localparam logic [ADDR:0] CNT_FULL = (ADDR+1)'(DEPTH);
  localparam logic [CA:0]   OCC_FULL = (CA+1)'(NCKPT);

  typedef struct packed {
    logic [ADDR-1:0]  tos;
    logic [ADDR:0]    cnt;
    logic [WIDTH-1:0] top;
  } ckpt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ckpt_t            ck  [NCKPT];

  logic [ADDR-1:0]  tos, tos_n, waddr;
  logic [ADDR:0]    cnt_n;
  logic [WIDTH-1:0] dout_n, wdata;
  logic [CA-1:0]    head, tail;
  logic [CA:0]      occ;
  logic             we, ovf_n, unf_n, drop_n;
  logic             ck_any, ci_take, do_deq, do_enq;
  ckpt_t            h;

  function automatic logic [CA-1:0] nxt(input logic [CA-1:0] p);
    return (p == CA'(NCKPT-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ck_any  = (occ != '0);
    ci_take = close_invalid && ck_any;
    h       = ck[head];
    tos_n   = tos;
    cnt_n   = count;
    we      = 1'b0;
    waddr   = tos;
    wdata   = din;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    if (ci_take) begin
      // Repair: only the snapshot's top entry is rewritten.
      tos_n = h.tos;
      cnt_n = h.cnt;
      we    = 1'b1;
      waddr = h.tos;
      wdata = h.top;
    end else if (push && (!pop || count == '0)) begin
      tos_n = tos + 1'b1;
      we    = 1'b1;
      waddr = tos + 1'b1;
      if (count == CNT_FULL) ovf_n = 1'b1;
      else                   cnt_n = count + 1'b1;
    end else if (pop && !push) begin
      if (count != '0) begin
        tos_n = tos - 1'b1;
        cnt_n = count - 1'b1;
      end else begin
        unf_n = 1'b1;
      end
    end else if (push && pop) begin
      we = 1'b1;
    end

    if (cnt_n == '0)                dout_n = '0;
    else if (we && waddr == tos_n)  dout_n = wdata;
    else                            dout_n = mem[tos_n];

    do_deq = !ci_take && close_valid && ck_any;
    do_enq = !ci_take && branch && (occ != OCC_FULL || do_deq);
    drop_n = !ci_take && branch && !do_enq;
  end

  always_ff @(posedge clk) begin
    if (!rst && we) mem[waddr] <= wdata;
    if (!rst && do_enq) ck[tail] <= '{tos: tos_n, cnt: cnt_n, top: dout_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos       <= '0;
      count     <= '0;
      dout      <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ckpt_drop <= 1'b0;
    end else begin
      tos       <= tos_n;
      count     <= cnt_n;
      dout      <= dout_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
      ckpt_drop <= drop_n;
      if (ci_take) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (do_enq) tail <= nxt(tail);
        if (do_deq) head <= nxt(head);
        occ <= occ + {{CA{1'b0}}, do_enq} - {{CA{1'b0}}, do_deq};
      end
    end
  end

  assign empty     = (count == '0);
  assign ckpt_full = (occ == OCC_FULL);

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboarded bench for ras_ckpt (DEPTH=4, NCKPT=2): directed plan items plus random traffic.
module tb_ras_ckpt;
  localparam int W = 32;
  localparam int D = 4;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst, push, pop, branch, close_valid, close_invalid;
  logic [W-1:0] din, dout;
  logic [2:0]   count;
  logic         empty, ckpt_full, overflow, underflow, ckpt_drop;

  ras_ckpt #(.WIDTH(W), .DEPTH(D), .NCKPT(N)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .branch(branch), .close_valid(close_valid), .close_invalid(close_invalid),
    .dout(dout), .count(count), .empty(empty), .ckpt_full(ckpt_full),
    .overflow(overflow), .underflow(underflow), .ckpt_drop(ckpt_drop)
  );

  always #5 clk = ~clk;

  typedef struct {int tos; int cnt; logic [W-1:0] top;} mck_t;
  typedef struct packed {
    logic [W-1:0] dout; logic [2:0] cnt;
    logic empty, full, ovf, unf, drop;
  } exp_t;

  mck_t         mq[$];
  exp_t         sb[$];
  logic [W-1:0] m_mem [D];
  int           m_tos, m_cnt;
  logic [W-1:0] m_dout;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic cyc(input logic r, input logic p, input logic q, input logic [W-1:0] d,
                     input logic b, input logic cv, input logic ci);
    exp_t e;
    mck_t h;
    logic ovf, unf, drop;
    rst = r; push = p; pop = q; din = d; branch = b; close_valid = cv; close_invalid = ci;
    ovf = 1'b0; unf = 1'b0; drop = 1'b0;
    if (r) begin
      m_tos = 0; m_cnt = 0; m_dout = '0; mq.delete();
    end else if (ci && mq.size() > 0) begin
      h = mq[0];
      m_tos = h.tos; m_cnt = h.cnt; m_mem[h.tos] = h.top; m_dout = h.top;
      mq.delete();
    end else begin
      if (p && (!q || m_cnt == 0)) begin
        m_tos = (m_tos + 1) % D;
        m_mem[m_tos] = d;
        if (m_cnt == D) ovf = 1'b1; else m_cnt++;
      end else if (q && !p) begin
        if (m_cnt > 0) begin m_tos = (m_tos + D - 1) % D; m_cnt--; end
        else unf = 1'b1;
      end else if (p && q) begin
        m_mem[m_tos] = d;
      end
      m_dout = (m_cnt == 0) ? '0 : m_mem[m_tos];
      if (cv && mq.size() > 0) void'(mq.pop_front());
      if (b) begin
        if (mq.size() < N) mq.push_back('{m_tos, m_cnt, m_dout});
        else drop = 1'b1;
      end
    end
    e.dout = m_dout; e.cnt = 3'(m_cnt); e.empty = (m_cnt == 0);
    e.full = (mq.size() == N); e.ovf = ovf; e.unf = unf; e.drop = drop;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("dout", dout, e.dout);
    chk("count", count, e.cnt);
    chk("empty", empty, e.empty);
    chk("ckpt_full", ckpt_full, e.full);
    chk("overflow", overflow, e.ovf);
    chk("underflow", underflow, e.unf);
    chk("ckpt_drop", ckpt_drop, e.drop);
  endtask

  task automatic psh(input logic [W-1:0] d); cyc(0, 1, 0, d, 0, 0, 0); endtask
  task automatic pp();                        cyc(0, 0, 1, '0, 0, 0, 0); endtask

  initial begin
    rst = 1'b1; push = 0; pop = 0; din = '0; branch = 0; close_valid = 0; close_invalid = 0;
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cyc(1, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), $urandom,
          1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)));
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dout", dout, 0);
    chk("rst_pulses", {ckpt_full, overflow, underflow, ckpt_drop}, 0);

    // Push/pop
    psh(32'h100); psh(32'h200); psh(32'h300);
    chk("pp_count3", count, 3);
    chk("pp_dout300", dout, 32'h300);
    pp();
    chk("pp_dout200", dout, 32'h200);
    chk("pp_count2", count, 2);
    pp(); pp();

    // Overflow / underflow
    for (int i = 1; i <= 5; i++) begin
      psh(W'(i));
      chk($sformatf("ovf_push%0d", i), overflow, (i == 5));
    end
    chk("ovf_count", count, 4);
    for (int i = 5; i >= 2; i--) begin
      chk($sformatf("pop_top%0d", i), dout, i);
      pp();
    end
    chk("drain_empty", empty, 1);
    chk("drain_dout", dout, 0);
    pp();
    chk("unf_pulse", underflow, 1);
    chk("unf_count", count, 0);

    // Replace top
    psh(32'h100); psh(32'h200);
    cyc(0, 1, 1, 32'h900, 0, 0, 0);
    chk("rep_count", count, 2);
    chk("rep_dout", dout, 32'h900);
    pp();
    chk("rep_below", dout, 32'h100);
    pp();

    // Mispredict repair
    psh(32'h10); psh(32'h20);
    cyc(0, 0, 0, '0, 1, 0, 0);
    pp(); psh(32'h99); psh(32'h98);
    cyc(0, 0, 0, '0, 0, 0, 1);
    chk("mis_count", count, 2);
    chk("mis_dout", dout, 32'h20);
    chk("mis_qempty", ckpt_full, 0);
    pp();
    chk("mis_below", dout, 32'h10);
    pp();

    // Checkpoint queue full
    cyc(0, 1, 0, 32'hA, 1, 0, 0);
    cyc(0, 1, 0, 32'hB, 1, 0, 0);
    cyc(0, 1, 0, 32'hC, 1, 0, 0);
    chk("cf_drop", ckpt_drop, 1);
    chk("cf_full", ckpt_full, 1);
    cyc(0, 0, 0, '0, 0, 1, 0);
    cyc(0, 0, 0, '0, 0, 0, 1);
    chk("cf_count", count, 2);
    chk("cf_dout", dout, 32'hB);
    chk("cf_notfull", ckpt_full, 0);
    cyc(0, 0, 0, '0, 0, 0, 1);
    chk("cf_idle_count", count, 2);
    chk("cf_idle_dout", dout, 32'hB);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0,63) == 0), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
          $urandom, ($urandom_range(0,3) == 0), ($urandom_range(0,4) == 0),
          ($urandom_range(0,9) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Parametrised circular return-address stack with multi-level speculative checkpointing. It sits beside the fetch unit's branch predictor:
- calls push the return address;
- returns read the predicted target from `dout` and pop;
- each in-flight conditional branch takes a checkpoint;
- in-order branch resolution either releases the oldest checkpoint or repairs the stack to it.

It generalises the single-branch speculative stack to `NCKPT` nested branches, with bounded depth, overflow wrap and explicit status flags.

## Interface
- `WIDTH`, 32, return-address width in bits
- `DEPTH`, 16, stack entries (power of two, ≥2)
- `ADDR`, `$clog2(DEPTH)`, stack pointer width
- `NCKPT`, 4, maximum outstanding checkpoints (power of two, ≥1)
- `CADDR`, `$clog2(NCKPT)`, checkpoint queue pointer width
- `clk` in 1 — single clock, all state updates on rising edge
- `rst` in 1 — reset; synchronous, active-high
- `push` in 1 — push `din` (a call)
- `pop` in 1 — remove top entry (a return)
- `din` in `WIDTH` — address to push
- `branch` in 1 — allocate a checkpoint
- `close_valid` in 1 — oldest branch resolved correct; free its checkpoint
- `close_invalid` in 1 — oldest branch mispredicted; restore its checkpoint, squash all
- `dout` out `WIDTH` — current top of stack (0 when empty)
- `count` out `ADDR+1` — valid entries, 0..`DEPTH`
- `empty` out 1 — `count == 0`
- `ckpt_full` out 1 — `NCKPT` checkpoints outstanding
- `overflow` out 1 — one-cycle pulse: a push discarded the oldest entry
- `underflow` out 1 — one-cycle pulse: pop while empty
- `ckpt_drop` out 1 — one-cycle pulse: `branch` refused because the queue was full

## Operation
- **State**
  - Storage `mem[DEPTH]`, not reset.
  - `tos` (index of the top entry) and `count`.
  - Checkpoint FIFO of `NCKPT` entries, each holding `{tos, count, top_value}`, with head/tail/occupancy.
- **Stack ops** (evaluated only when `close_invalid = 0`)
  - Push only: `tos += 1` mod `DEPTH`, `mem[tos] = din`. `count` increments and saturates at `DEPTH`. At `DEPTH` the oldest entry is overwritten and `overflow` pulses.
  - Pop only:
    - `count > 0`: `tos -= 1` mod `DEPTH`, `count -= 1`.
    - `count == 0`: no state change, `underflow` pulses.
  - Push and pop together (tail-call / replace top):
    - `count > 0`: `mem[tos] = din`; `tos` and `count` unchanged.
    - `count == 0`: behaves as push only.
  - Neither: hold.
- **`dout`**
  - Registered copy of `mem[tos]` after the cycle's operation.
  - 0 whenever the resulting `count == 0`.
  - The consumer samples `dout` in the same cycle it asserts `pop`.
- **`branch`**
  - Not full: enqueue at the tail a snapshot of `{tos, count, dout}` as they stand *after* the same cycle's stack op.
  - Full: ignored, `ckpt_drop` pulses.
- **`close_valid`**
  - Dequeues the oldest checkpoint.
  - Ignored if the queue is empty.
  - Same cycle as `branch` (queue non-full or freeing): both take effect, and occupancy is unchanged.
- **`close_invalid`**
  - With at least one checkpoint (`H` = the oldest):
    - `tos = H.tos`, `count = H.count`;
    - `mem[H.tos] = H.top_value`;
    - `dout = H.top_value`;
    - the whole queue is flushed.
  - `push`, `pop`, `branch` and `close_valid` in the same cycle are ignored.
  - With no checkpoint: ignored entirely, and the stack ops proceed normally.
  - Priority: `close_invalid` > `close_valid`/`branch` > stack ops for checkpoint state.
- **Repair precision**
  - Exact for the top entry.
  - Entries below the snapshot top that were overwritten by speculative pops then pushes are not repaired. This is accepted predictor behaviour.
- **Arithmetic**
  - `tos` wraps modulo `DEPTH`.
  - `count` never exceeds `DEPTH` and never goes below 0.
  - Checkpoint pointers wrap modulo `NCKPT`.

## Timing
- Reset values:
  - `tos = 0`, `count = 0`, `empty = 1`, `dout = 0`;
  - checkpoint queue empty, `ckpt_full = 0`;
  - `overflow = underflow = ckpt_drop = 0`.
- `rst` overrides all other inputs in the same cycle, including mid-speculation: all checkpoints are lost.
- All outputs are registered. The effect of the inputs at edge *n* is visible after edge *n*, i.e. one-cycle latency.
- Back-to-back operations are supported every cycle with no stalls; there is no ready/valid handshake.
- Pulse flags are high for exactly the one cycle following the causing edge.

## Test plan
- **Reset:** assert `rst` 2 cycles with random inputs → `count=0`, `empty=1`, `dout=0`, `ckpt_full=0`, all pulses 0.
- **Push/pop:** push `0x100`, `0x200`, `0x300` → `count=3`, `dout=0x300`. Then pop → `dout=0x200`, `count=2`.
- **Overflow/underflow (`DEPTH=4`):**
  - Push 1..5 → `overflow` pulses on the 5th only, `count=4`.
  - Pops yield `dout` 5, 4, 3, 2 before each pop, then `empty=1`, `dout=0`.
  - A 5th pop → `underflow` pulses, `count` stays 0.
- **Replace top:** with stack (`0x100`, `0x200`), push+pop with `din=0x900` → `count=2`, `dout=0x900`. A following pop → `dout=0x100`.
- **Mispredict repair:**
  - Push `0x10`, `0x20`; `branch`; pop; push `0x99`; push `0x98`; `close_invalid` → `count=2`, `dout=0x20`, queue empty.
  - Then pop → `dout=0x10`.
- **Checkpoint full (`NCKPT=2`):**
  - Snapshots: push `0xA`, `branch`; push `0xB`, `branch`; push `0xC`, `branch` → `ckpt_drop` pulses on the third branch, `ckpt_full=1`.
  - `close_valid` then `close_invalid` → `count=2`, `dout=0xB`, `ckpt_full=0`.
  - `close_invalid` again with an empty queue → no change.
